// File: rtl/tft_spi_tx_pkg.sv
// ============================================================================
// Module  : tft_spi_tx_pkg
// Brief   : Shared state encoding, D/C constants and helpers for the TFT SPI TX
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tft_spi_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOW  = 3'd1,
        ST_HIGH = 3'd2,
        ST_HOLD = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    localparam logic c_TFT_DC_COMM = 1'b0;
    localparam logic c_TFT_DC_DATA = 1'b1;

    // Terminal count for an n-cycle phase; n==0 phases are never entered.
    function automatic logic [7:0] last_tick(input int n);
        return (n > 0) ? 8'(n - 1) : 8'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tft_spi_div.sv
// ============================================================================
// Module  : tft_spi_div
// Brief   : 8-bit phase counter; ticks on the last cycle of a phase, then wraps
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tft_spi_div (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [7:0] i_last,
    output logic       o_tick
);

    logic [7:0] r_cnt;

    assign o_tick = (r_cnt == i_last);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_en) begin
            r_cnt <= o_tick ? 8'd0 : r_cnt + 8'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tft_spi_tx.sv
// ============================================================================
// Module  : tft_spi_tx
// Brief   : Byte-level SPI mode-0 transmitter for the TFT panel, CS framed per byte
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tft_spi_tx
    import tft_spi_tx_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_transmit,
    input  logic       i_dc,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_spi_sck,
    output logic       o_spi_mosi,
    output logic       o_spi_cs_n,
    output logic       o_spi_dc
);

    localparam logic [7:0] c_DIV_LAST = last_tick(CLK_DIV);
    localparam logic [7:0] c_GAP_LAST = last_tick(CS_GAP);

    state_t     r_state, w_state;
    logic [7:0] r_shreg, w_shreg;
    logic [2:0] r_bit_cnt, w_bit_cnt;
    logic       r_sck, w_sck;
    logic       r_mosi, w_mosi;
    logic       r_cs_n, w_cs_n;
    logic       r_dc, w_dc;
    logic       w_tick;
    logic [7:0] w_last;

    assign w_last = (r_state == ST_GAP) ? c_GAP_LAST : c_DIV_LAST;

    tft_spi_div u_div (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (r_state == ST_IDLE),
        .i_en   (1'b1),
        .i_last (w_last),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shreg   <= 8'd0;
            r_bit_cnt <= 3'd0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_dc      <= c_TFT_DC_COMM;
        end else begin
            r_state   <= w_state;
            r_shreg   <= w_shreg;
            r_bit_cnt <= w_bit_cnt;
            r_sck     <= w_sck;
            r_mosi    <= w_mosi;
            r_cs_n    <= w_cs_n;
            r_dc      <= w_dc;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_shreg   = r_shreg;
        w_bit_cnt = r_bit_cnt;
        w_sck     = r_sck;
        w_mosi    = r_mosi;
        w_cs_n    = r_cs_n;
        w_dc      = r_dc;
        case (r_state)
            ST_IDLE: begin
                if (i_transmit) begin
                    w_shreg   = i_data;
                    w_dc      = i_dc;
                    w_cs_n    = 1'b0;
                    w_mosi    = i_data[7];
                    w_bit_cnt = 3'd7;
                    w_state   = ST_LOW;
                end
            end
            ST_LOW: begin
                if (w_tick) begin
                    w_sck   = 1'b1;
                    w_state = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_tick) begin
                    w_sck = 1'b0;
                    if (r_bit_cnt == 3'd0) begin
                        w_state = ST_HOLD;
                    end else begin
                        // Rotate rather than shift so every shreg bit stays live; MSB is next bit.
                        w_shreg   = {r_shreg[6:0], r_shreg[7]};
                        w_mosi    = r_shreg[6];
                        w_bit_cnt = r_bit_cnt - 3'd1;
                        w_state   = ST_LOW;
                    end
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    w_cs_n  = 1'b1;
                    w_state = (CS_GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    w_state = ST_IDLE;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign o_busy     = (r_state != ST_IDLE);
    assign o_spi_sck  = r_sck;
    assign o_spi_mosi = r_mosi;
    assign o_spi_cs_n = r_cs_n;
    assign o_spi_dc   = r_dc;

endmodule

`default_nettype wire

// File: tb/tb_tft_spi_tx.sv
// ============================================================================
// Module  : tb_tft_spi_tx
// Brief   : Self-checking bench for tft_spi_tx with a frame-level panel monitor
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tft_spi_tx;
    import tft_spi_tx_pkg::*;

    localparam int DIV_A = 2;
    localparam int GAP_A = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       transmit = 1'b0, dc = 1'b0;
    logic [7:0] data = 8'd0;
    logic       busy, sck, mosi, cs_n, sdc;
    logic       transmit_b = 1'b0, dc_b = 1'b0;
    logic [7:0] data_b = 8'd0;
    logic       busy_b, sck_b, mosi_b, cs_n_b, sdc_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tft_spi_tx #(.CLK_DIV(DIV_A), .CS_GAP(GAP_A)) u_dut (
        .clk(clk), .rst(rst), .i_transmit(transmit), .i_dc(dc), .i_data(data),
        .o_busy(busy), .o_spi_sck(sck), .o_spi_mosi(mosi), .o_spi_cs_n(cs_n), .o_spi_dc(sdc)
    );

    tft_spi_tx #(.CLK_DIV(1), .CS_GAP(0)) u_dut_fast (
        .clk(clk), .rst(rst), .i_transmit(transmit_b), .i_dc(dc_b), .i_data(data_b),
        .o_busy(busy_b), .o_spi_sck(sck_b), .o_spi_mosi(mosi_b), .o_spi_cs_n(cs_n_b), .o_spi_dc(sdc_b)
    );

    // Panel-side view: each CS_N frame becomes one record.
    typedef struct {
        logic       dc;
        logic [7:0] b;
        int         nbits;
        int         dcok;
        int         lead;
        int         trail;
    } frame_t;

    typedef struct {
        logic       dc;
        logic [7:0] b;
    } exp_t;

    frame_t fq[$];
    exp_t   exp_q[$];
    int     busy_q[$];
    int     cs_q[$];

    int         cyc = 0, t_fall = 0, last_fall = 0, lead = 0;
    int         m_bits = 0, m_dcok = 1, busy_run = 0, cs_run = 0;
    logic [7:0] m_byte = 8'd0;
    logic       m_dc = 1'b0, prev_cs = 1'b1, prev_sck = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (prev_cs && !cs_n) begin
            m_bits = 0; m_byte = 8'd0; m_dc = sdc; m_dcok = 1; t_fall = cyc;
        end
        if (!cs_n && sdc !== m_dc) m_dcok = 0;
        if (!prev_sck && sck && !cs_n) begin
            m_byte = {m_byte[6:0], mosi};
            if (m_bits == 0) lead = cyc - t_fall;
            m_bits++;
        end
        if (prev_sck && !sck) last_fall = cyc;
        if (!prev_cs && cs_n) begin
            frame_t f;
            f.dc = m_dc; f.b = m_byte; f.nbits = m_bits; f.dcok = m_dcok;
            f.lead = lead; f.trail = cyc - last_fall;
            fq.push_back(f);
        end
        if (busy === 1'b1) busy_run++;
        else if (busy_run > 0) begin busy_q.push_back(busy_run); busy_run = 0; end
        if (cs_n === 1'b0) cs_run++;
        else if (cs_run > 0) begin cs_q.push_back(cs_run); cs_run = 0; end
        prev_cs = cs_n;
        prev_sck = sck;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic d, input logic [7:0] b);
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin @(negedge clk); n++; end
        chk("send_wait_timeout", (n < 300), 1);
        transmit = 1'b1; dc = d; data = b;
        exp_q.push_back('{d, b});
        @(negedge clk);
        transmit = 1'b0;
        dc = 1'($urandom);
        data = 8'($urandom);
        chk("accepted_first_idle", busy, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin @(negedge clk); n++; end
        chk("idle_timeout", (n < 300), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frames();
        while (exp_q.size() > 0) begin
            exp_t e;
            frame_t f;
            e = exp_q.pop_front();
            chk("frame_present", (fq.size() > 0), 1);
            if (fq.size() == 0) continue;
            f = fq.pop_front();
            chk("frame_dc", f.dc, e.dc);
            chk("frame_byte", f.b, e.b);
            chk("frame_nbits", f.nbits, 8);
            chk("frame_dc_stable", f.dcok, 1);
            chk("cs_to_first_rise", f.lead, DIV_A);
            chk("last_fall_to_cs", f.trail, DIV_A);
            chk("busy_len_present", (busy_q.size() > 0), 1);
            if (busy_q.size() > 0) chk("busy_len", busy_q.pop_front(), 17 * DIV_A + GAP_A);
            chk("cs_len_present", (cs_q.size() > 0), 1);
            if (cs_q.size() > 0) chk("cs_low_len", cs_q.pop_front(), 17 * DIV_A);
        end
        chk("no_extra_frames", fq.size(), 0);
    endtask

    initial begin
        // 1: reset then idle
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_cs_n", cs_n, 1'b1);
            chk("rst_sck", sck, 1'b0);
            chk("rst_mosi", mosi, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_dc", sdc, c_TFT_DC_COMM);
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_cs_n", cs_n, 1'b1);
            chk("idle_busy", busy, 1'b0);
        end

        // 2: single command byte
        send(c_TFT_DC_COMM, 8'hC0);
        wait_idle();
        check_frames();

        // 3: sequencer-style back-to-back command then data
        send(c_TFT_DC_COMM, 8'h2A);
        send(c_TFT_DC_DATA, 8'h00);
        send(c_TFT_DC_DATA, 8'h00);
        send(c_TFT_DC_DATA, 8'h01);
        send(c_TFT_DC_DATA, 8'h3F);
        wait_idle();
        chk("dc_holds_in_idle", sdc, c_TFT_DC_DATA);
        check_frames();

        // random bytes and D/C values
        for (int i = 0; i < 8; i++) send(1'($urandom), 8'($urandom));
        wait_idle();
        check_frames();

        // 4: transmit while busy is ignored
        send(c_TFT_DC_DATA, 8'h55);
        repeat (10) @(negedge clk);
        transmit = 1'b1; data = 8'hFF;
        @(negedge clk);
        transmit = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);
        check_frames();

        // rst together with transmit: byte not accepted
        rst = 1'b1; transmit = 1'b1; data = 8'h99;
        @(negedge clk);
        rst = 1'b0; transmit = 1'b0;
        chk("rst_wins_busy", busy, 1'b0);
        chk("rst_wins_cs_n", cs_n, 1'b1);
        repeat (5) @(negedge clk);
        chk("rst_wins_no_frame", busy, 1'b0);

        // 5: reset at the 4th SCK rise
        send(c_TFT_DC_DATA, 8'hA5);
        void'(exp_q.pop_back());
        @(negedge clk);
        begin
            int n = 0;
            while (m_bits < 4 && n < 100) begin @(negedge clk); n++; end
            chk("fourth_rise_timeout", (n < 100), 1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cs_n", cs_n, 1'b1);
        chk("midrst_sck", sck, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        fq.delete(); busy_q.delete(); cs_q.delete();
        send(c_TFT_DC_DATA, 8'h3C);
        wait_idle();
        check_frames();

        // 6: CLK_DIV=1, CS_GAP=0 instance
        begin
            int         bcnt = 0, nb = 0, last_rise = -1, n = 0;
            logic [7:0] got = 8'd0;
            logic       ps = 1'b0;
            transmit_b = 1'b1; dc_b = 1'b1; data_b = 8'h81;
            @(negedge clk);
            transmit_b = 1'b0; data_b = 8'h00;
            while (busy_b === 1'b1 && n < 60) begin
                bcnt++;
                if (!ps && sck_b) begin
                    got = {got[6:0], mosi_b};
                    if (last_rise >= 0) chk("fast_sck_period", n - last_rise, 2);
                    last_rise = n;
                    nb++;
                end
                ps = sck_b;
                @(negedge clk);
                n++;
            end
            chk("fast_busy_len", bcnt, 17);
            chk("fast_nbits", nb, 8);
            chk("fast_byte", got, 8'h81);
            chk("fast_cs_n_after", cs_n_b, 1'b1);
            chk("fast_dc", sdc_b, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
